// File: rtl/gp3_pio_pkg.sv
// Shared constants for the gp3 PIO family: register map, edge-mode codes and
// the debounce counter sizing rule.
package gp3_pio_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // ceil(log2(cycles+1)), never narrower than one bit so the vector stays legal.
   function automatic int cnt_width(input int cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/gp3_pio_debounce.sv
// One PIO input bit: two-flop synchroniser followed by an optional
// stable-for-N-clocks debounce filter.
module gp3_pio_debounce
   import gp3_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_async,
   output logic o_stable
);

   logic r_meta;
   logic r_sync;
   logic r_stable;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the two synchroniser stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_stable <= 1'b0;
            else          r_stable <= r_sync;
         end
      end else begin : g_filter
         localparam int CW = cnt_width(DEBOUNCE_CYCLES);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] r_cnt;

         // The new level is accepted on the DEBOUNCE_CYCLES-th consecutive
         // differing sample; any agreeing sample restarts the count.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_cnt    <= '0;
               r_stable <= 1'b0;
            end else if (r_sync == r_stable) begin
               r_cnt <= '0;
            end else if (r_cnt >= LAST) begin
               r_stable <= r_sync;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   endgenerate

   assign o_stable = r_stable;

endmodule

// File: rtl/gp3_edge_pio.sv
// Edge-capturing parallel input port: synchronised/debounced inputs, sticky
// edge-capture register, interrupt mask and a registered level interrupt.
module gp3_edge_pio
   import gp3_pio_pkg::*;
#(
   parameter int WIDTH           = 3,
   parameter int EDGE_MODE       = 0,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] r_stable_d;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clear;
   logic [WIDTH-1:0] r_capture;
   logic [WIDTH-1:0] r_mask;
   logic [31:0]      w_rdata;
   logic [31:0]      r_rdata;
   logic             r_irq;
   logic             w_wr;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gp3_pio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .i_async (in_port[i]),
         .o_stable(w_stable[i])
      );
   end

   assign w_wr    = chipselect & ~write_n;
   assign w_rise  = w_stable & ~r_stable_d;
   assign w_fall  = ~w_stable & r_stable_d;
   assign w_clear = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

   // NOTE: every combinational output gets a default first so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      w_edge = w_rise;
      case (EDGE_MODE)
         EDGE_FALL: w_edge = w_fall;
         EDGE_ANY:  w_edge = w_rise | w_fall;
         default:   w_edge = w_rise;
      endcase
   end

   always_comb begin
      w_rdata = '0;
      case (address)
         ADDR_DATA: w_rdata[WIDTH-1:0] = w_stable;
         ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
         ADDR_EDGE: w_rdata[WIDTH-1:0] = r_capture;
         default:   w_rdata = '0;
      endcase
   end

   // A fresh edge is OR-ed in after the clear, so it survives a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stable_d <= '0;
         r_capture  <= '0;
         r_mask     <= '0;
         r_rdata    <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_stable_d <= w_stable;
         r_capture  <= (r_capture & ~w_clear) | w_edge;
         if (w_wr && address == ADDR_MASK) r_mask <= writedata[WIDTH-1:0];
         r_rdata    <= w_rdata;
         r_irq      <= |(r_capture & r_mask);
      end
   end

   assign readdata = r_rdata;
   assign irq      = r_irq;

endmodule

// File: tb/tb_gp3_edge_pio.sv
// Directed bench for gp3_edge_pio: a vector table on a rising-edge, no-debounce
// instance plus hand sequences for any-edge, debounce and reset behaviour.
module tb_gp3_edge_pio;
   import gp3_pio_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic        cs_a, cs_b, cs_c;
   logic [2:0]  in_a, in_b, in_c;
   logic [31:0] rd_a, rd_b, rd_c;
   logic        irq_a, irq_b, irq_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gp3_edge_pio #(.WIDTH(3), .EDGE_MODE(0), .DEBOUNCE_CYCLES(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
      .write_n(write_n), .writedata(writedata), .in_port(in_a),
      .readdata(rd_a), .irq(irq_a));

   gp3_edge_pio #(.WIDTH(3), .EDGE_MODE(2), .DEBOUNCE_CYCLES(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
      .write_n(write_n), .writedata(writedata), .in_port(in_b),
      .readdata(rd_b), .irq(irq_b));

   gp3_edge_pio #(.WIDTH(3), .EDGE_MODE(0), .DEBOUNCE_CYCLES(4)) dut_c (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_c),
      .write_n(write_n), .writedata(writedata), .in_port(in_c),
      .readdata(rd_c), .irq(irq_c));

   typedef struct {
      logic [2:0]  in;
      logic [1:0]  addr;
      logic        cs;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [2:0] in, input logic [1:0] addr, input logic cs,
                      input logic wr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_irq);
      vec_t v;
      v.in = in; v.addr = addr; v.cs = cs; v.wr = wr; v.wdata = wdata;
      v.exp_rd = exp_rd; v.exp_irq = exp_irq;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      address = 2'd0; write_n = 1'b1; writedata = '0;
      cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
      in_a = '0; in_b = '0; in_c = '0;

      // Rising mode, mask 010: bit-1 edge, clear, same-cycle edge/clear, ignored writes.
      add(3'b101, 0, 0, 0, 0, 0, 0);
      add(3'b101, 0, 0, 0, 0, 0, 0);
      add(3'b101, 0, 0, 0, 0, 0, 0);
      add(3'b101, 0, 0, 0, 0, 5, 0);
      add(3'b101, 3, 0, 0, 0, 5, 0);
      add(3'b101, 2, 1, 1, 2, 0, 0);
      add(3'b101, 2, 0, 0, 0, 2, 0);
      add(3'b111, 3, 0, 0, 0, 5, 0);
      add(3'b111, 3, 0, 0, 0, 5, 0);
      add(3'b111, 3, 0, 0, 0, 5, 0);
      add(3'b111, 3, 0, 0, 0, 5, 0);
      add(3'b111, 3, 0, 0, 0, 7, 1);
      add(3'b111, 3, 1, 1, 2, 7, 1);
      add(3'b111, 3, 0, 0, 0, 5, 0);
      add(3'b111, 3, 1, 1, 5, 5, 0);
      add(3'b111, 3, 0, 0, 0, 0, 0);
      add(3'b011, 3, 0, 0, 0, 0, 0);
      add(3'b011, 3, 0, 0, 0, 0, 0);
      add(3'b011, 3, 0, 0, 0, 0, 0);
      add(3'b011, 3, 0, 0, 0, 0, 0);
      add(3'b111, 3, 0, 0, 0, 0, 0);
      add(3'b111, 3, 0, 0, 0, 0, 0);
      add(3'b111, 3, 0, 0, 0, 0, 0);
      add(3'b111, 3, 1, 1, 4, 0, 0);
      add(3'b111, 3, 0, 0, 0, 4, 0);
      add(3'b111, 2, 1, 1, 6, 2, 0);
      add(3'b111, 2, 0, 0, 0, 6, 1);
      add(3'b111, 0, 1, 1, 32'hFFFF_FFFF, 7, 1);
      add(3'b111, 1, 1, 1, 32'hFFFF_FFFF, 0, 1);
      add(3'b111, 2, 0, 0, 0, 6, 1);
      add(3'b111, 3, 0, 0, 0, 4, 1);
      add(3'b111, 3, 0, 1, 4, 4, 1);
      add(3'b111, 3, 0, 0, 0, 4, 1);

      tick();
      tick();
      check("reset_rd_a", rd_a, 0);
      check("reset_rd_b", rd_b, 0);
      check("reset_rd_c", rd_c, 0);
      check("reset_irq_a", 32'(irq_a), 0);
      check("reset_irq_b", 32'(irq_b), 0);
      check("reset_irq_c", 32'(irq_c), 0);
      #3 reset_n = 1'b1;

      foreach (vecs[i]) begin
         in_a      = vecs[i].in;
         address   = vecs[i].addr;
         cs_a      = vecs[i].cs;
         write_n   = ~vecs[i].wr;
         writedata = vecs[i].wdata;
         tick();
         check($sformatf("vec%0d_rd", i), rd_a, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), 32'(irq_a), 32'(vecs[i].exp_irq));
      end
      cs_a = 1'b0; write_n = 1'b1; writedata = '0;

      // Any-edge instance: rise captured, cleared, then fall captured with mask 0.
      address = 2'd3;
      in_b = 3'b001;
      repeat (5) tick();
      check("b_rise_any", rd_b, 1);
      cs_b = 1'b1; write_n = 1'b0; writedata = 32'h1;
      tick();
      cs_b = 1'b0; write_n = 1'b1;
      in_b = 3'b000;
      tick();
      check("b_cleared", rd_b, 0);
      repeat (4) tick();
      check("b_fall_capture", rd_b, 1);
      check("b_irq_masked", 32'(irq_b), 0);
      address = 2'd2; cs_b = 1'b1; write_n = 1'b0; writedata = 32'h1;
      tick();
      cs_b = 1'b0; write_n = 1'b1;
      check("b_irq_write_cycle", 32'(irq_b), 0);
      tick();
      check("b_irq_after_mask", 32'(irq_b), 1);
      check("b_mask_read", rd_b, 1);

      // Debounce of 4: a 3-clock pulse is rejected, a held level lands after 4 samples.
      address = 2'd0;
      in_c = 3'b001;
      repeat (3) tick();
      in_c = 3'b000;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("c_pulse_%0d", k), rd_c, 0);
      end
      in_c = 3'b001;
      repeat (6) tick();
      check("c_hold_early", rd_c, 0);
      tick();
      check("c_hold_exact", rd_c, 1);

      // Reset mid-debounce with all inputs high.
      in_c = 3'b111;
      repeat (4) tick();
      check("c_pre_reset", rd_c, 1);
      check("a_irq_pre_reset", 32'(irq_a), 1);
      #3 reset_n = 1'b0;
      #1;
      check("async_rd_a", rd_a, 0);
      check("async_rd_b", rd_b, 0);
      check("async_rd_c", rd_c, 0);
      check("async_irq_a", 32'(irq_a), 0);
      check("async_irq_b", 32'(irq_b), 0);
      tick();
      tick();
      check("held_rd_c", rd_c, 0);
      #3 reset_n = 1'b1;
      repeat (6) tick();
      check("c_post_reset_early", rd_c, 0);
      tick();
      check("c_post_reset_full", rd_c, 7);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
